// File: rtl/usb_tx_pkg.sv
// Shared types for the USB low/full-speed transmitter.
//   d_port_t    : line state driven onto D+/D- (J, K, SE0)
//   tx_state_t  : transmitter FSM states, padded to a full 3-bit space
//   SYNC_PATTERN: byte shifted out (LSB first) as the packet SYNC field
//   nrzi_toggle : J<->K swap used by NRZI encoding and stuff bits
package types;

  // Encoded as {D+, D-}.
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10
  } d_port_t;

  // All eight encodings are named so the state register decodes fully.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5,
    ST_RSVD6   = 3'd6,
    ST_RSVD7   = 3'd7
  } tx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  function automatic d_port_t nrzi_toggle(input d_port_t lvl);
    return (lvl == J) ? K : J;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the terminal count.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   clear  : holds the count at zero (no strobes while asserted)
//   strobe : high during the last cycle of each bit period
module bit_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic strobe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign strobe = (count == TERMINAL) && !clear;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || strobe) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx.sv
// USB 2.0 low/full-speed packet transmitter.
// Takes bytes from the SIE over a valid/ready handshake and drives one
// packet: SYNC, NRZI-encoded bit-stuffed payload, then EOP (SE0 SE0 J).
//   clk    : system clock
//   reset  : asynchronous, active-high
//   data   : byte from SIE, sent LSB first
//   valid  : SIE has a byte on data, held until ready
//   ready  : one-cycle pulse, data captured (coincides with bit 0 on d)
//   active : high from first SYNC bit until end of EOP J bit
//   oe     : port output enable
//   d      : driven line state
module usb_tx
  import types::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       active,
  output logic       oe,
  output d_port_t    d
);

  tx_state_t  state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_idx, bit_idx_n;   // bit within byte; reused as EOP SE0 counter
  logic [2:0] ones, ones_n;         // consecutive transmitted ones
  d_port_t    d_n;
  logic       oe_n, active_n, ready_n;
  logic       strobe;

  // Scratch for the "begin a new payload bit" action shared by three paths.
  logic       start_bit, bit_val, adv, byte_end;
  d_port_t    lvl_base;
  logic [2:0] ones_base;

  bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_IDLE),
    .strobe (strobe)
  );

  // NOTE: every variable assigned here gets a default first; otherwise a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    ones_n    = ones;
    d_n       = d;
    oe_n      = oe;
    active_n  = active;
    ready_n   = 1'b0;
    start_bit = 1'b0;
    bit_val   = 1'b0;
    lvl_base  = d;
    ones_base = ones;
    adv       = 1'b0;
    byte_end  = 1'b0;

    case (state)
      ST_IDLE: begin
        d_n      = J;
        oe_n     = 1'b0;
        active_n = 1'b0;
        if (valid) begin
          // Packet starts from a J level with a clean ones count.
          state_n   = ST_SYNC;
          shift_n   = SYNC_PATTERN;
          bit_idx_n = 3'd0;
          lvl_base  = J;
          ones_base = 3'd0;
          start_bit = 1'b1;
          bit_val   = SYNC_PATTERN[0];
          oe_n      = 1'b1;
          active_n  = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          if (ones == 3'd6) begin
            state_n = ST_STUFF;
            d_n     = nrzi_toggle(d);
            ones_n  = 3'd0;
          end else if (bit_idx == 3'd7) begin
            byte_end = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      ST_STUFF: begin
        // Bit index was not advanced by the stuff bit, so bit 7 here means
        // the stuff was owed after the last bit of the byte.
        if (strobe) begin
          if (bit_idx == 3'd7) begin
            byte_end = 1'b1;
          end else begin
            adv     = 1'b1;
            state_n = ST_DATA;
          end
        end
      end
      ST_EOP_SE0: begin
        if (strobe) begin
          if (bit_idx == 3'd0) begin
            bit_idx_n = 3'd1;
          end else begin
            state_n = ST_EOP_J;
            d_n     = J;
          end
        end
      end
      ST_EOP_J: begin
        if (strobe) begin
          state_n  = ST_IDLE;
          d_n      = J;
          oe_n     = 1'b0;
          active_n = 1'b0;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        d_n      = J;
        oe_n     = 1'b0;
        active_n = 1'b0;
      end
    endcase

    if (adv) begin
      bit_idx_n = bit_idx + 3'd1;
      shift_n   = {1'b0, shift[7:1]};
      start_bit = 1'b1;
      bit_val   = shift[1];
    end

    if (byte_end) begin
      if (valid) begin
        state_n   = ST_DATA;
        shift_n   = data;
        bit_idx_n = 3'd0;
        ready_n   = 1'b1;
        start_bit = 1'b1;
        bit_val   = data[0];
      end else begin
        state_n   = ST_EOP_SE0;
        d_n       = SE0;
        bit_idx_n = 3'd0;
      end
    end

    // NRZI: a 0 toggles the line, a 1 holds it and extends the ones run.
    if (start_bit) begin
      if (bit_val) begin
        d_n    = lvl_base;
        ones_n = ones_base + 3'd1;
      end else begin
        d_n    = nrzi_toggle(lvl_base);
        ones_n = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      ones    <= '0;
      d       <= J;
      oe      <= 1'b0;
      active  <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      ones    <= ones_n;
      d       <= d_n;
      oe      <= oe_n;
      active  <= active_n;
      ready   <= ready_n;
    end
  end

endmodule
